warp_lane_sequencer: RTL

Downstream consumer of the registered warp-mask stage: accepts one warp's active mask (plus its registered active-lane count) per handshake and serializes it into one lane ID per cycle, lowest lane first, for a narrow execution or address-generation unit. It flags the last active lane of each warp and the ordinal of each issued lane. It back-to-back accepts the next warp on the same cycle the last lane drains, so a fully active stream runs with no bubbles.

---
 rtl/warp_lane_sequencer_if.sv | 27 ++
 rtl/warp_lane_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/warp_lane_sequencer_if.sv
// Handshake bundle between the warp-mask producer, the lane sequencer and the lane consumer.
// master = environment side (drives masks, accepts lanes); slave = sequencer side.
interface warp_lane_sequencer_if #(
  parameter int WARP_SIZE     = 32,
  parameter int LANE_ID_WIDTH = 5,
  parameter int CNT_WIDTH     = 6
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [WARP_SIZE-1:0]     in_mask;
  logic [CNT_WIDTH-1:0]     in_count;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANE_ID_WIDTH-1:0] out_lane;
  logic                     out_last;
  logic [CNT_WIDTH-1:0]     out_idx;

  modport master (
    output in_valid, in_mask, in_count, out_ready,
    input  in_ready, out_valid, out_lane, out_last, out_idx
  );

  modport slave (
    input  in_valid, in_mask, in_count, out_ready,
    output in_ready, out_valid, out_lane, out_last, out_idx
  );
endinterface

// File: rtl/warp_lane_sequencer.sv
// Serializes a warp active mask into one lane ID per cycle, lowest lane first.
// Optional popcount cross-check of in_count is built only when WARP_SEQ_COUNT_CHECK_EN is defined.
module warp_lane_sequencer #(
  parameter int WARP_SIZE     = 32,
  parameter int LANE_ID_WIDTH = 5,
  parameter int CNT_WIDTH     = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  warp_lane_sequencer_if.slave        bus,
  output logic                        count_err
);
  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [WARP_SIZE-1:0] ZERO_W = {WARP_SIZE{1'b0}};
  localparam logic [WARP_SIZE-1:0] ONE_W  = {{(WARP_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ZERO_C = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] ONE_C  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r, state_s;
  logic [WARP_SIZE-1:0] pending_r, pending_s;
  logic [CNT_WIDTH-1:0] idx_r, idx_s;
  logic                 has_lane_s, last_s, take_s, ready_s, accept_s;

  function automatic logic [LANE_ID_WIDTH-1:0] lowest_lane(input logic [WARP_SIZE-1:0] m);
    lowest_lane = {LANE_ID_WIDTH{1'b0}};
    for (int i = WARP_SIZE - 1; i >= 0; i--) begin
      if (m[i]) lowest_lane = LANE_ID_WIDTH'(i);
    end
  endfunction

  // Handshake decode; in_ready depends combinationally on out_ready so warps chain without bubbles
  always_comb begin
    has_lane_s = (state_r == ISSUE);
    last_s     = (pending_r != ZERO_W) && ((pending_r & (pending_r - ONE_W)) == ZERO_W);
    take_s     = has_lane_s && bus.out_ready;
    ready_s    = (state_r == IDLE) || (take_s && last_s);
    accept_s   = bus.in_valid && ready_s;
  end

  // Next-state logic: a new accept overrides the drain of the final lane
  always_comb begin
    state_s   = state_r;
    pending_s = pending_r;
    idx_s     = idx_r;
    if (accept_s) begin
      if (bus.in_mask != ZERO_W) begin
        pending_s = bus.in_mask;
        idx_s     = ZERO_C;
        state_s   = ISSUE;
      end else begin
        pending_s = ZERO_W;
        idx_s     = ZERO_C;
        state_s   = IDLE;
      end
    end else begin
      case (state_r)
        ISSUE: begin
          if (take_s && last_s) begin
            pending_s = ZERO_W;
            idx_s     = ZERO_C;
            state_s   = IDLE;
          end else if (take_s) begin
            pending_s = pending_r & (pending_r - ONE_W);
            idx_s     = idx_r + ONE_C;
          end else begin
            pending_s = pending_r;
            idx_s     = idx_r;
          end
        end
        IDLE: begin
          pending_s = ZERO_W;
          idx_s     = ZERO_C;
        end
        default: begin
          pending_s = ZERO_W;
          idx_s     = ZERO_C;
          state_s   = IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state only (plus the in_ready handshake term)
  always_comb begin
    bus.in_ready  = ready_s;
    bus.out_valid = has_lane_s;
    bus.out_lane  = lowest_lane(pending_r);
    bus.out_last  = last_s;
    bus.out_idx   = idx_r;
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= ZERO_W;
      idx_r     <= ZERO_C;
    end else begin
      state_r   <= state_s;
      pending_r <= pending_s;
      idx_r     <= idx_s;
    end
  end

`ifdef WARP_SEQ_COUNT_CHECK_EN
  logic count_err_r;
  logic mismatch_s;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [WARP_SIZE-1:0] m);
    popcount = {CNT_WIDTH{1'b0}};
    for (int i = 0; i < WARP_SIZE; i++) begin
      popcount = popcount + CNT_WIDTH'(m[i]);
    end
  endfunction

  // An all-zero mask with a zero count is trivially consistent and skipped
  always_comb begin
    mismatch_s = accept_s
              && ((bus.in_mask != ZERO_W) || (bus.in_count != ZERO_C))
              && (bus.in_count != popcount(bus.in_mask));
  end

  // Sticky count mismatch flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_err_r <= 1'b0;
    end else if (mismatch_s) begin
      count_err_r <= 1'b1;
    end else begin
      count_err_r <= count_err_r;
    end
  end

  assign count_err = count_err_r;
`else
  logic unused_count_s;
  assign unused_count_s = ^bus.in_count;
  assign count_err      = 1'b0;
`endif

endmodule
